// File: rtl/rtc_responder.sv
// Multiplexed address/data bus slave fronting a 16-entry register file whose
// registers 1..3 hold a BCD seconds/minutes/hours clock driven by a prescaler.
module rtc_responder #(
    parameter int unsigned TICK_CYCLES = 100000000,
    parameter int unsigned NREG        = 16
) (
    input  logic       reloj,
    input  logic       resetM,
    input  logic       CS,
    input  logic       RD,
    input  logic       WR,
    input  logic       A_D,
    input  logic [7:0] AD_in,
    output logic [7:0] AD_out,
    output logic       AD_oe,
    output logic       proto_err
);

    localparam int unsigned DW    = 8;
    localparam int unsigned CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_CYCLES - 1);
    localparam logic [DW-1:0] SEC_LIM = 8'h59;
    localparam logic [DW-1:0] HR_LIM  = 8'h23;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ADDR      = 3'd1;
    localparam logic [2:0] S_WAIT_DATA = 3'd2;
    localparam logic [2:0] S_WRITE     = 3'd3;
    localparam logic [2:0] S_READ      = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [DW-1:0]    addr_q, addr_d;
    logic [DW-1:0]    regs_q [NREG];
    logic [DW-1:0]    regs_d [NREG];
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ad_oe_q, ad_oe_d;
    logic [DW-1:0]    ad_out_q, ad_out_d;
    logic             perr_q, perr_d;
    logic             cs_q, cs_d, rd_q, rd_d, wr_q, wr_d, ad_q, ad_d;
    logic             wr_prev_q, wr_prev_d;
    logic [DW-1:0]    din_q, din_d, din_prev_q, din_prev_d;

    logic             wr_rise, tick, host_we;
    logic [DW-1:0]    rd_val;
    logic [DW:0]      sec_n, min_n, hr_n;

    // Saturating BCD increment: digits above 9 count as 9; returns {carry, value}.
    function automatic logic [DW:0] bcd_inc(input logic [DW-1:0] v, input logic [DW-1:0] lim);
        logic [3:0]    tens;
        logic [3:0]    ones;
        logic [DW-1:0] clamp;
        tens  = (v[7:4] > 4'd9) ? 4'd9 : v[7:4];
        ones  = (v[3:0] > 4'd9) ? 4'd9 : v[3:0];
        clamp = {tens, ones};
        if (v == lim || clamp > lim) begin
            bcd_inc = {1'b1, 8'h00};
        end else if (ones == 4'd9) begin
            bcd_inc = {1'b0, tens + 4'd1, 4'd0};
        end else begin
            bcd_inc = {1'b0, tens, ones + 4'd1};
        end
    endfunction

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        regs_d     = regs_q;
        ad_oe_d    = 1'b0;
        ad_out_d   = 8'h00;
        perr_d     = perr_q;
        cs_d       = CS;
        rd_d       = RD;
        wr_d       = WR;
        ad_d       = A_D;
        wr_prev_d  = wr_q;
        din_d      = AD_in;
        din_prev_d = din_q;
        host_we    = 1'b0;
        wr_rise    = wr_q & ~wr_prev_q;
        tick       = (cnt_q == CNT_LAST);
        rd_val     = (addr_q[7:4] == 4'd0) ? regs_q[addr_q[3:0]] : 8'h00;
        sec_n      = bcd_inc(regs_q[1], SEC_LIM);
        min_n      = bcd_inc(regs_q[2], SEC_LIM);
        hr_n       = bcd_inc(regs_q[3], HR_LIM);
        cnt_d      = tick ? '0 : cnt_q + CNT_W'(1);

        case (state_q)
            S_IDLE: begin
                if (!cs_q && !wr_q && !ad_q) state_d = S_ADDR;
            end
            S_ADDR: begin
                // din_prev holds the bus value from the last cycle WR was low
                if (wr_rise) begin
                    addr_d  = din_prev_q;
                    state_d = S_WAIT_DATA;
                end else if (cs_q) begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT_DATA: begin
                if (cs_q) begin
                    state_d = S_IDLE;
                end else if (ad_q && !wr_q && rd_q) begin
                    state_d = S_WRITE;
                end else if (ad_q && !rd_q && wr_q) begin
                    state_d  = S_READ;
                    ad_oe_d  = 1'b1;
                    ad_out_d = rd_val;
                end
            end
            S_WRITE: begin
                if (wr_rise) begin
                    host_we = (addr_q[7:4] == 4'd0);
                    state_d = S_IDLE;
                end else if (cs_q) begin
                    state_d = S_IDLE;
                end
            end
            S_READ: begin
                if (rd_q || cs_q) begin
                    state_d = S_IDLE;
                end else begin
                    ad_oe_d  = 1'b1;
                    ad_out_d = ad_out_q;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (!cs_q && !rd_q && (!ad_q || !wr_q)) perr_d = 1'b1;
        if (state_q == S_IDLE && !cs_q && ad_q && (!rd_q || !wr_q)) perr_d = 1'b1;

        // Tick chain is computed from old values; a host write then overrides its target.
        if (tick) begin
            regs_d[1] = sec_n[DW-1:0];
            if (sec_n[DW]) begin
                regs_d[2] = min_n[DW-1:0];
                if (min_n[DW]) regs_d[3] = hr_n[DW-1:0];
            end
        end
        if (host_we) begin
            regs_d[addr_q[3:0]] = din_prev_q;
            if (addr_q[3:0] == 4'd1) cnt_d = '0;
        end
    end

    always_ff @(posedge reloj or negedge resetM) begin
        if (!resetM) begin
            state_q    <= S_IDLE;
            addr_q     <= 8'h00;
            for (int i = 0; i < NREG; i++) regs_q[i] <= 8'h00;
            cnt_q      <= '0;
            ad_oe_q    <= 1'b0;
            ad_out_q   <= 8'h00;
            perr_q     <= 1'b0;
            cs_q       <= 1'b1;
            rd_q       <= 1'b1;
            wr_q       <= 1'b1;
            ad_q       <= 1'b1;
            wr_prev_q  <= 1'b1;
            din_q      <= 8'h00;
            din_prev_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            regs_q     <= regs_d;
            cnt_q      <= cnt_d;
            ad_oe_q    <= ad_oe_d;
            ad_out_q   <= ad_out_d;
            perr_q     <= perr_d;
            cs_q       <= cs_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            ad_q       <= ad_d;
            wr_prev_q  <= wr_prev_d;
            din_q      <= din_d;
            din_prev_q <= din_prev_d;
        end
    end

    assign AD_out    = ad_out_q;
    assign AD_oe     = ad_oe_q;
    assign proto_err = perr_q;

endmodule

// File: tb/tb_rtc_responder.sv
// Bench for rtc_responder: transaction-level driver, decimal-arithmetic clock
// model, and a per-cycle comparison of AD_oe / AD_out / proto_err.
module tb_rtc_responder;

    localparam int unsigned T   = 4;
    localparam int          INF = 1 << 30;

    logic       reloj, resetM, CS, RD, WR, A_D;
    logic [7:0] AD_in, AD_out;
    logic       AD_oe, proto_err;

    rtc_responder #(.TICK_CYCLES(T), .NREG(16)) dut (
        .reloj(reloj), .resetM(resetM), .CS(CS), .RD(RD), .WR(WR), .A_D(A_D),
        .AD_in(AD_in), .AD_out(AD_out), .AD_oe(AD_oe), .proto_err(proto_err)
    );

    initial begin
        reloj = 1'b0;
        forever #5 reloj = ~reloj;
    end

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // model state (written only by the model process)
    int         cyc = 0;
    logic [7:0] m_regs [16];
    int         m_cnt = 0;
    logic [7:0] m_rdval = 8'h00;
    logic [7:0] m_nxt [16];
    logic [7:0] m_v;
    bit         m_c, m_tick;

    // transaction bookkeeping (written only by the driver)
    int         mw_due = -1, mw_addr = 0, cap_cycle = -1, rd_a = 0;
    logic [7:0] mw_data = 8'h00;
    int         oe_from = 0, oe_until = 0, pe_from = INF;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) << 4) + (v % 10));
    endfunction

    // Clock-digit increment done in decimal: clamp digits, wrap past the limit.
    function automatic void m_inc(input logic [7:0] raw, input int lim,
                                  output logic [7:0] nv, output bit carry);
        int hi, lo, v;
        hi = int'(raw[7:4]);
        lo = int'(raw[3:0]);
        if (hi > 9) hi = 9;
        if (lo > 9) lo = 9;
        v = hi * 10 + lo;
        if (v > lim || (v == lim && raw[7:4] <= 4'd9 && raw[3:0] <= 4'd9)) begin
            nv = 8'h00;
            carry = 1'b1;
        end else begin
            nv = to_bcd(v + 1);
            carry = 1'b0;
        end
    endfunction

    always @(posedge reloj or negedge resetM) begin
        if (!resetM) begin
            for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
            m_cnt = 0;
            m_rdval = 8'h00;
        end else begin
            cyc++;
            m_tick = (m_cnt == int'(T) - 1);
            m_nxt = m_regs;
            if (m_tick) begin
                m_inc(m_regs[1], 59, m_v, m_c);
                m_nxt[1] = m_v;
                if (m_c) begin
                    m_inc(m_regs[2], 59, m_v, m_c);
                    m_nxt[2] = m_v;
                    if (m_c) begin
                        m_inc(m_regs[3], 23, m_v, m_c);
                        m_nxt[3] = m_v;
                    end
                end
            end
            m_cnt = m_tick ? 0 : m_cnt + 1;
            if (cyc == mw_due) begin
                m_nxt[mw_addr] = mw_data;
                if (mw_addr == 1) m_cnt = 0;
            end
            m_regs = m_nxt;
            if (cyc == cap_cycle) m_rdval = (rd_a < 16) ? m_regs[rd_a] : 8'h00;
        end
    end

    always @(negedge reloj) begin
        if (chk_en) begin
            automatic bit e_oe = (cyc >= oe_from) && (cyc < oe_until);
            check("ad_oe", 32'(AD_oe), 32'(e_oe));
            check("ad_out", 32'(AD_out), e_oe ? 32'(m_rdval) : 32'h0);
            check("proto_err", 32'(proto_err), 32'(cyc >= pe_from));
        end
    end

    task automatic step();
        @(posedge reloj);
        #1;
    endtask

    task automatic drv(input logic cs, input logic rd, input logic wr, input logic ad,
                       input logic [7:0] d);
        CS = cs; RD = rd; WR = wr; A_D = ad; AD_in = d;
    endtask

    task automatic do_reset();
        step();
        mw_due = -1; cap_cycle = -1; oe_from = 0; oe_until = 0; pe_from = INF;
        drv(1, 1, 1, 1, 8'h00);
        resetM = 1'b0;
        @(negedge reloj);
        check("rst_oe", 32'(AD_oe), 32'h0);
        check("rst_out", 32'(AD_out), 32'h0);
        check("rst_perr", 32'(proto_err), 32'h0);
        step();
        step();
        resetM = 1'b1;
    endtask

    // Leaves WR high with the address still on the bus; caller is at that cycle.
    task automatic addr_phase(input logic [7:0] a);
        step(); drv(0, 1, 0, 0, a);
        step(); step(); drv(0, 1, 1, 0, a);
    endtask

    task automatic wr_txn(input logic [7:0] a, input logic [7:0] d, input bit abort,
                          input bit collide);
        addr_phase(a);
        step();
        if (abort) begin
            drv(1, 1, 1, 1, 8'h00);
            step(); step(); step();
            return;
        end
        drv(0, 1, 0, 1, d);
        step(); step();
        if (collide) begin
            for (int g = 0; g < 8 && m_cnt != 2; g++) step();
            check("collide_align", 32'(m_cnt), 32'd2);
        end
        drv(0, 1, 1, 1, d);
        if (a < 8'd16) begin
            mw_addr = int'(a); mw_data = d; mw_due = cyc + 2;
        end
        step(); drv(1, 1, 1, 1, 8'h00);
        step();
        if (collide) begin
            check("collide_reg1", 32'(m_regs[1]), 32'(d));
            check("collide_presc", 32'(m_cnt), 32'd0);
        end
        step();
    endtask

    task automatic rd_txn(input logic [7:0] a, output logic [7:0] obs);
        addr_phase(a);
        step();
        drv(0, 0, 1, 1, 8'h00);
        rd_a = int'(a); cap_cycle = cyc + 1; oe_from = cyc + 2; oe_until = INF;
        step(); step(); step();
        @(negedge reloj);
        obs = AD_out;
        RD = 1'b1;
        oe_until = cyc + 2;
        step(); drv(1, 1, 1, 1, 8'h00);
        step(); step();
    endtask

    function automatic logic [7:0] pick_addr();
        int r = $urandom_range(0, 9);
        if (r < 4) return 8'($urandom_range(1, 3));
        if (r < 8) return 8'($urandom_range(0, 15));
        return 8'($urandom_range(16, 255));
    endfunction

    function automatic logic [7:0] pick_data(input logic [7:0] a);
        if (a >= 8'd1 && a <= 8'd3 && $urandom_range(0, 1) == 1) begin
            if (a == 8'd3) return to_bcd($urandom_range(19, 23));
            return to_bcd($urandom_range(55, 59));
        end
        return 8'($urandom_range(0, 255));
    endfunction

    task automatic random_traffic(input int n);
        logic [7:0] a, obs;
        int kind;
        for (int i = 0; i < n; i++) begin
            kind = $urandom_range(0, 9);
            a = pick_addr();
            if (kind < 5)      wr_txn(a, pick_data(a), 1'b0, 1'b0);
            else if (kind < 8) rd_txn(a, obs);
            else               wr_txn(a, 8'h5A, 1'b1, 1'b0);
            repeat ($urandom_range(0, 3)) step();
        end
    endtask

    logic [7:0] obs, pv;
    bit pc;

    initial begin
        resetM = 1'b1;
        drv(1, 1, 1, 1, 8'h00);
        #2;
        do_reset();
        chk_en = 1'b1;

        m_inc(8'h5A, 59, pv, pc); check("model_5a", {23'd0, pc, pv}, 32'h060);
        m_inc(8'h60, 59, pv, pc); check("model_60", {23'd0, pc, pv}, 32'h100);
        m_inc(8'h23, 23, pv, pc); check("model_23", {23'd0, pc, pv}, 32'h100);
        m_inc(8'h19, 23, pv, pc); check("model_19", {23'd0, pc, pv}, 32'h020);

        wr_txn(8'h05, 8'hA7, 1'b0, 1'b0);
        rd_txn(8'h05, obs); check("rd_05", 32'(obs), 32'hA7);

        wr_txn(8'h12, 8'h3C, 1'b0, 1'b0);
        rd_txn(8'h12, obs); check("rd_12_oor", 32'(obs), 32'h00);
        check("oor_perr", 32'(proto_err), 32'h0);

        wr_txn(8'h07, 8'h55, 1'b1, 1'b0);
        rd_txn(8'h07, obs); check("rd_07_abort", 32'(obs), 32'h00);
        wr_txn(8'h07, 8'h66, 1'b0, 1'b0);
        rd_txn(8'h07, obs); check("rd_07_after", 32'(obs), 32'h66);

        wr_txn(8'h01, 8'h00, 1'b0, 1'b0);
        wr_txn(8'h03, 8'h23, 1'b0, 1'b0);
        wr_txn(8'h02, 8'h59, 1'b0, 1'b0);
        wr_txn(8'h01, 8'h59, 1'b0, 1'b0);
        rd_txn(8'h02, obs); check("roll_min", 32'(obs), 32'h00);
        rd_txn(8'h03, obs); check("roll_hr", 32'(obs), 32'h00);

        wr_txn(8'h01, 8'h30, 1'b0, 1'b1);
        rd_txn(8'h01, obs);

        random_traffic(150);

        // RD low with A_D low while selected
        step(); drv(0, 0, 1, 0, 8'h00);
        if (pe_from > cyc + 2) pe_from = cyc + 2;
        step(); drv(1, 1, 1, 1, 8'h00);
        step(); step(); step();
        check("perr_set", 32'(proto_err), 32'h1);
        wr_txn(8'h0A, 8'h42, 1'b0, 1'b0);
        rd_txn(8'h0A, obs); check("rd_0a", 32'(obs), 32'h42);
        check("perr_sticky", 32'(proto_err), 32'h1);

        addr_phase(8'h09);
        step(); drv(0, 1, 0, 1, 8'h77);
        step(); step();
        do_reset();
        check("perr_cleared", 32'(proto_err), 32'h0);
        wr_txn(8'h04, 8'h99, 1'b0, 1'b0);
        rd_txn(8'h04, obs); check("rd_04", 32'(obs), 32'h99);
        rd_txn(8'h09, obs); check("rd_09_rst", 32'(obs), 32'h00);

        // data phase while idle
        step(); drv(0, 1, 0, 1, 8'hEE);
        if (pe_from > cyc + 2) pe_from = cyc + 2;
        step(); step(); drv(1, 1, 1, 1, 8'h00);
        step(); step();
        check("perr_idle_data", 32'(proto_err), 32'h1);

        random_traffic(20);
        repeat (4) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
